// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//   Requester side of a combinational ALU. A request is accepted over a
//   valid/ready handshake and held in a one-entry issue register. That
//   register drives the ALU for exactly one cycle. At the end of that cycle
//   the ALU result and its n/z/v flags are pushed, with the request tag,
//   into an in-order response FIFO.
//
//   Operand A can be replaced by the most recent result (forwarding). A
//   saturating counter records how many ADD/SUB results retired with
//   overflow.
//
// Ports
//   CLK, RST          clock, async active-high reset
//   req_*             request handshake: op, a, b, fwd_a, tag
//   aluop/port_a/b    operands driven to the ALU (held while idle)
//   port_o, n, z, v   ALU result and flags
//   rsp_*             response FIFO head (zeros while empty); pops on
//                     rsp_valid && rsp_ready
//   ovf_count         saturating count of retired ADD/SUB with v=1
// ---------------------------------------------------------------------------
module alu_issue #(
  parameter int WORD_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  input  logic              req_fwd_a,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [3:0]        aluop,
  output logic [WORD_W-1:0] port_a,
  output logic [WORD_W-1:0] port_b,
  input  logic [WORD_W-1:0] port_o,
  input  logic              n,
  input  logic              z,
  input  logic              v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_n,
  output logic              rsp_z,
  output logic              rsp_v,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;

  typedef struct packed {
    logic [3:0]        op;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } req_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              n;
    logic              z;
    logic              v;
    logic [TAG_W-1:0]  tag;
  } rsp_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic              iss_vld;
  req_t              iss_q;
  logic [WORD_W-1:0] last_result;
  rsp_t              mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  logic [PW-1:0] fifo_cnt;
  logic [PW:0]   occ;
  logic          req_fire;
  logic          rsp_fire;
  logic          retire;

  assign fifo_cnt = wr_ptr - rd_ptr;

  // The issue entry counts against FIFO space. Because of this, the entry
  // always finds a free slot one cycle later and the stage never stalls.
  // Only registered state is used here, so rsp_ready cannot reach req_ready.
  assign occ       = {1'b0, fifo_cnt} + (PW+1)'(iss_vld);
  assign req_ready = occ < (PW+1)'(DEPTH);
  assign req_fire  = req_valid & req_ready;
  assign rsp_valid = fifo_cnt != '0;
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign retire    = iss_vld;

  // -------------------------------------------------------------------------
  // Issue stage
  // -------------------------------------------------------------------------
  logic [WORD_W-1:0] fwd_val;
  logic [WORD_W-1:0] op_a;

  // When an entry is retiring this cycle, its result is only visible on
  // port_o. Otherwise the newest result is the one held in last_result.
  assign fwd_val = iss_vld ? port_o : last_result;
  assign op_a    = req_fwd_a ? fwd_val : req_a;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      iss_vld <= 1'b0;
      iss_q   <= '0;
    end else begin
      iss_vld <= req_fire;
      // Fields load only on a handshake. As a result the ALU operands hold
      // their last values while the stage is empty.
      if (req_fire) begin
        iss_q.op  <= req_op;
        iss_q.a   <= op_a;
        iss_q.b   <= req_b;
        iss_q.tag <= req_tag;
      end
    end
  end

  assign aluop  = iss_q.op;
  assign port_a = iss_q.a;
  assign port_b = iss_q.b;

  // -------------------------------------------------------------------------
  // Retire: last result and overflow counter
  // -------------------------------------------------------------------------
  logic ovf_hit;

  assign ovf_hit = retire & v & ((iss_q.op == ALU_ADD) | (iss_q.op == ALU_SUB));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_result <= '0;
      ovf_count   <= '0;
    end else begin
      if (retire) last_result <= port_o;
      if (ovf_hit && (ovf_count != '1)) ovf_count <= ovf_count + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Response FIFO
  // -------------------------------------------------------------------------
  // Storage needs no reset. The pointers define which entries are valid, and
  // the outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (retire) begin
      mem[wr_ptr[AW-1:0]].data <= port_o;
      mem[wr_ptr[AW-1:0]].n    <= n;
      mem[wr_ptr[AW-1:0]].z    <= z;
      mem[wr_ptr[AW-1:0]].v    <= v;
      mem[wr_ptr[AW-1:0]].tag  <= iss_q.tag;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (retire)   wr_ptr <= wr_ptr + PW'(1);
      if (rsp_fire) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  rsp_t head;

  always_comb begin
    head = '0;
    if (rsp_valid) head = mem[rd_ptr[AW-1:0]];
  end

  assign rsp_data = head.data;
  assign rsp_n    = head.n;
  assign rsp_z    = head.z;
  assign rsp_v    = head.v;
  assign rsp_tag  = head.tag;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  localparam int WORD_W = 32;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [31:0] r;
    logic        n;
    logic        z;
    logic        v;
  } alu_t;

  typedef struct packed {
    logic [31:0] d;
    logic        n;
    logic        z;
    logic        v;
    logic [3:0]  tag;
  } rsp_t;

  logic CLK = 1'b0;
  logic RST;
  logic req_valid, req_ready, req_fwd_a;
  logic [3:0] req_op, aluop;
  logic [WORD_W-1:0] req_a, req_b, port_a, port_b, port_o, rsp_data;
  logic [TAG_W-1:0] req_tag, rsp_tag;
  logic n, z, v, rsp_valid, rsp_ready, rsp_n, rsp_z, rsp_v;
  logic [CNT_W-1:0] ovf_count;
  logic force_v;

  alu_issue #(.WORD_W(WORD_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_fwd_a(req_fwd_a), .req_tag(req_tag),
    .aluop(aluop), .port_a(port_a), .port_b(port_b),
    .port_o(port_o), .n(n), .z(z), .v(v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_v(rsp_v), .rsp_tag(rsp_tag),
    .ovf_count(ovf_count)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU. force_v injects an overflow flag on any opcode.
  function automatic alu_t alu_f(input logic [3:0] op, input logic [31:0] a, b, input logic fv);
    alu_t o;
    o.v = 1'b0;
    case (op)
      4'd0:  o.r = a << b[4:0];
      4'd1:  o.r = a >> b[4:0];
      4'd2:  begin o.r = a + b; o.v = (a[31] == b[31]) && (o.r[31] != a[31]); end
      4'd3:  begin o.r = a - b; o.v = (a[31] != b[31]) && (o.r[31] != a[31]); end
      4'd4:  o.r = a & b;
      4'd5:  o.r = a | b;
      4'd6:  o.r = a ^ b;
      4'd7:  o.r = ~(a | b);
      4'd10: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11: o.r = (a < b) ? 32'd1 : 32'd0;
      default: o.r = 32'h0;
    endcase
    o.n = o.r[31];
    o.z = (o.r == 32'h0);
    o.v = o.v | fv;
    return o;
  endfunction

  alu_t alu_r;
  always_comb alu_r = alu_f(aluop, port_a, port_b, force_v);
  assign port_o = alu_r.r;
  assign n = alu_r.n;
  assign z = alu_r.z;
  assign v = alu_r.v;

  int checks = 0;
  int errors = 0;
  rsp_t sb_q[$];
  logic [31:0] exp_last;
  int max_occ = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one request and hold it until accepted. The expected response is
  // queued once the handshake has taken place.
  task automatic send(input logic [3:0] op, input logic [31:0] a, b, input logic fwd, input logic [3:0] tag);
    int w;
    logic acc;
    alu_t e;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_fwd_a = fwd; req_tag = tag;
    acc = 1'b0; w = 0;
    while (!acc && w < 200) begin
      @(negedge CLK); acc = req_ready;
      @(posedge CLK); #1; w++;
    end
    req_valid = 1'b0;
    chk("send_accept", {63'd0, acc}, 64'd1);
    if (acc) begin
      e = alu_f(op, fwd ? exp_last : a, b, force_v);
      exp_last = e.r;
      sb_q.push_back({e.r, e.n, e.z, e.v, tag});
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      @(posedge CLK); #1; w++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: compares every popped head against the scoreboard.
  initial begin
    rsp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > max_occ) max_occ = sb_q.size();
      if (!RST && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got tag %0h data %0h expected no response", rsp_tag, rsp_data);
        end else begin
          e = sb_q.pop_front();
          chk("rsp", {23'd0, rsp_data, rsp_n, rsp_z, rsp_v, rsp_tag}, {23'd0, e});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] ops [12];

  initial begin
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11, 4'd12, 4'd15};
    RST = 1'b1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_fwd_a = 0; req_tag = 0;
    rsp_ready = 1'b1; force_v = 1'b0; exp_last = 0;
    #2;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_aluop", 64'(aluop), 64'd0);
    chk("rst_port_a", 64'(port_a), 64'd0);
    chk("rst_port_b", 64'(port_b), 64'd0);
    chk("rst_ovf", 64'(ovf_count), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    @(posedge CLK); #1; RST = 1'b0;
    @(posedge CLK); #1;

    // Single ADD: 5+7, two-cycle latency
    send(4'd2, 32'd5, 32'd7, 1'b0, 4'd3);
    chk("t1_aluop", 64'(aluop), 64'd2);
    chk("t1_port_a", 64'(port_a), 64'd5);
    chk("t1_port_b", 64'(port_b), 64'd7);
    chk("t1_no_early_rsp", 64'(rsp_valid), 64'd0);
    @(posedge CLK); #1;
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_data", 64'(rsp_data), 64'd12);
    chk("t1_rsp_z", 64'(rsp_z), 64'd0);
    chk("t1_rsp_tag", 64'(rsp_tag), 64'd3);
    drain();

    // Forward chain: 1+1, then fwd-2
    send(4'd2, 32'd1, 32'd1, 1'b0, 4'd0);
    send(4'd3, 32'hDEAD, 32'd2, 1'b1, 4'd1);
    chk("fwd_aluop", 64'(aluop), 64'd3);
    chk("fwd_port_a", 64'(port_a), 64'd2);
    chk("fwd_head_data", 64'(rsp_data), 64'd2);
    chk("fwd_head_tag", 64'(rsp_tag), 64'd0);
    @(posedge CLK); #1;
    chk("fwd2_data", 64'(rsp_data), 64'd0);
    chk("fwd2_z", 64'(rsp_z), 64'd1);
    chk("fwd2_tag", 64'(rsp_tag), 64'd1);
    drain();

    // Backpressure
    rsp_ready = 1'b0;
    send(4'd2, 32'd10, 32'd20, 1'b0, 4'd4);
    send(4'd6, 32'hF0, 32'hFF, 1'b0, 4'd5);
    @(negedge CLK);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk("bp_ready_still_low", 64'(req_ready), 64'd0);
    chk("bp_head_tag", 64'(rsp_tag), 64'd4);
    chk("bp_head_data", 64'(rsp_data), 64'd30);
    rsp_ready = 1'b1;
    send(4'd5, 32'd3, 32'd4, 1'b0, 4'd6);
    drain();

    // Mid-stream reset
    rsp_ready = 1'b0;
    send(4'd2, 32'd100, 32'd1, 1'b0, 4'd2);
    send(4'd2, 32'd200, 32'd1, 1'b0, 4'd3);
    RST = 1'b1;
    #1;
    chk("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mrst_req_ready", 64'(req_ready), 64'd1);
    chk("mrst_ovf", 64'(ovf_count), 64'd0);
    chk("mrst_aluop", 64'(aluop), 64'd0);
    sb_q.delete();
    exp_last = 0;
    @(posedge CLK); #1; RST = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("mrst_no_stale", 64'(rsp_valid), 64'd0);
    send(4'd2, 32'hFFFF, 32'd9, 1'b1, 4'd7);  // last_result cleared -> 0+9
    drain();

    // Overflow counter
    force_v = 1'b1;
    send(4'd0, 32'd1, 32'd1, 1'b0, 4'd8);
    drain();
    force_v = 1'b0;
    chk("ovf_sll_ignored", 64'(ovf_count), 64'd0);
    send(4'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'd9);
    drain();
    chk("ovf_one", 64'(ovf_count), 64'd1);
    for (int i = 0; i < 299; i++) send(4'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'(i));
    drain();
    chk("ovf_saturated", 64'(ovf_count), 64'd255);

    // Random churn
    begin
      bit churn_done;
      churn_done = 0;
      fork
        begin
          for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1)
              send(ops[$urandom_range(0, 11)], $urandom, $urandom_range(0, 40),
                   ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
            else begin
              @(posedge CLK); #1;
            end
          end
          churn_done = 1;
        end
        begin
          while (!churn_done) begin
            @(posedge CLK); #1;
            rsp_ready = ($urandom_range(0, 1) == 1);
          end
        end
      join
    end
    rsp_ready = 1'b1;
    drain();
    chk("max_fill", 64'(max_occ), 64'(DEPTH));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
